// File: rtl/csr_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_if
//  Description : Bundle of CSR access, trap/mret entry and fetch-redirect
//                signals between the core pipeline and csr_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_if #(
    parameter int XLEN           = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      csr_valid;
    logic [1:0]                csr_op;
    logic [CSR_ADDR_WIDTH-1:0] csr_addr;
    logic [XLEN-1:0]           csr_wdata;
    logic [XLEN-1:0]           csr_rdata;
    logic                      csr_illegal;
    logic                      trap_valid;
    logic                      trap_ready;
    logic [XLEN-1:0]           trap_pc;
    logic [XLEN-1:0]           trap_cause;
    logic                      mret_valid;
    logic                      instret_inc;
    logic                      redirect_valid;
    logic [XLEN-1:0]           redirect_pc;

    // Pipeline side
    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata,
        output trap_valid, trap_pc, trap_cause, mret_valid, instret_inc,
        input  csr_rdata, csr_illegal, trap_ready, redirect_valid, redirect_pc
    );

    // CSR unit side
    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata,
        input  trap_valid, trap_pc, trap_cause, mret_valid, instret_inc,
        output csr_rdata, csr_illegal, trap_ready, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_unit
//  Description : Machine-mode CSR file (mstatus, mtvec, mepc, mcause, mhartid,
//                optional 64-bit mcycle/minstret) with trap entry / mret
//                sequencing and a one-cycle PC redirect to fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_unit #(
    parameter int XLEN           = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int HAS_COUNTERS   = 1
) (
    input  logic  clk,
    input  logic  rst,
    csr_if.slave  bus
);

    localparam logic [1:0] c_OP_NONE = 2'b00;
    localparam logic [1:0] c_OP_RW   = 2'b01;
    localparam logic [1:0] c_OP_RS   = 2'b10;
    localparam logic [1:0] c_OP_RC   = 2'b11;

    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MSTATUS   = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MTVEC     = CSR_ADDR_WIDTH'(12'h305);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MEPC      = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MCAUSE    = CSR_ADDR_WIDTH'(12'h342);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MHARTID   = CSR_ADDR_WIDTH'(12'hF14);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MCYCLE    = CSR_ADDR_WIDTH'(12'hB00);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MINSTRET  = CSR_ADDR_WIDTH'(12'hB02);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MCYCLEH   = CSR_ADDR_WIDTH'(12'hB80);
    localparam logic [CSR_ADDR_WIDTH-1:0] c_ADDR_MINSTRETH = CSR_ADDR_WIDTH'(12'hB82);

    localparam int c_MIE_BIT  = 3;
    localparam int c_MPIE_BIT = 7;

    localparam logic            c_HAS_CNT    = (HAS_COUNTERS != 0);
    localparam logic            c_HAS_HI     = (HAS_COUNTERS != 0) && (XLEN == 32);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_REDIRECT = 1'b1;

    logic [0:0]      r_state;
    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [63:0]     r_mcycle;
    logic [63:0]     r_minstret;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic w_hit_mstatus, w_hit_mtvec, w_hit_mepc, w_hit_mcause, w_hit_mhartid;
    logic w_hit_mcycle, w_hit_minstret, w_hit_mcycleh, w_hit_minstreth;
    logic w_implemented;
    logic w_is_write;
    logic w_illegal;
    logic w_trap_ready;
    logic w_trap_take;
    logic w_mret_take;
    logic w_wr_en;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_wval;
    logic [63:0]     w_mcycle_nxt;
    logic [63:0]     w_minstret_nxt;

    // Address decode; counter addresses only exist when counters are built
    assign w_hit_mstatus   = (bus.csr_addr == c_ADDR_MSTATUS);
    assign w_hit_mtvec     = (bus.csr_addr == c_ADDR_MTVEC);
    assign w_hit_mepc      = (bus.csr_addr == c_ADDR_MEPC);
    assign w_hit_mcause    = (bus.csr_addr == c_ADDR_MCAUSE);
    assign w_hit_mhartid   = (bus.csr_addr == c_ADDR_MHARTID);
    assign w_hit_mcycle    = c_HAS_CNT && (bus.csr_addr == c_ADDR_MCYCLE);
    assign w_hit_minstret  = c_HAS_CNT && (bus.csr_addr == c_ADDR_MINSTRET);
    assign w_hit_mcycleh   = c_HAS_HI  && (bus.csr_addr == c_ADDR_MCYCLEH);
    assign w_hit_minstreth = c_HAS_HI  && (bus.csr_addr == c_ADDR_MINSTRETH);

    assign w_implemented = w_hit_mstatus | w_hit_mtvec | w_hit_mepc | w_hit_mcause |
                           w_hit_mhartid | w_hit_mcycle | w_hit_minstret |
                           w_hit_mcycleh | w_hit_minstreth;

    // Old-value read mux; unimplemented addresses and mhartid read zero
    always_comb begin
        w_rdata = '0;
        if (w_hit_mstatus) begin
            w_rdata[c_MIE_BIT]  = r_mie;
            w_rdata[c_MPIE_BIT] = r_mpie;
        end else if (w_hit_mtvec) begin
            w_rdata = r_mtvec;
        end else if (w_hit_mepc) begin
            w_rdata = r_mepc;
        end else if (w_hit_mcause) begin
            w_rdata = r_mcause;
        end else if (w_hit_mcycle) begin
            w_rdata = XLEN'(r_mcycle);
        end else if (w_hit_minstret) begin
            w_rdata = XLEN'(r_minstret);
        end else if (w_hit_mcycleh) begin
            w_rdata = XLEN'(r_mcycle >> 32);
        end else if (w_hit_minstreth) begin
            w_rdata = XLEN'(r_minstret >> 32);
        end
    end

    // New value produced by the read-modify-write operation
    always_comb begin
        w_wval = bus.csr_wdata;
        case (bus.csr_op)
            c_OP_RS: w_wval = w_rdata | bus.csr_wdata;
            c_OP_RC: w_wval = w_rdata & ~bus.csr_wdata;
            default: w_wval = bus.csr_wdata;
        endcase
    end

    // RS/RC with a zero mask is a pure read, so it never counts as a write
    assign w_is_write = bus.csr_valid &&
                        ((bus.csr_op == c_OP_RW) ||
                         (((bus.csr_op == c_OP_RS) || (bus.csr_op == c_OP_RC)) &&
                          (bus.csr_wdata != '0)));

    assign w_illegal = bus.csr_valid && (bus.csr_op != c_OP_NONE) &&
                       (!w_implemented || (w_is_write && w_hit_mhartid));

    // Trap beats mret beats CSR write; writes only land in IDLE outside reset
    assign w_trap_ready = (r_state == c_ST_IDLE) && !rst;
    assign w_trap_take  = w_trap_ready && bus.trap_valid;
    assign w_mret_take  = w_trap_ready && bus.mret_valid && !bus.trap_valid;
    assign w_wr_en      = w_is_write && !w_illegal && w_trap_ready &&
                          !bus.trap_valid && !bus.mret_valid;

    // Counter next values; a write to either half suppresses that counter's increment
    always_comb begin
        w_mcycle_nxt   = r_mcycle + 64'd1;
        w_minstret_nxt = r_minstret + {63'd0, bus.instret_inc};
        if (w_wr_en && w_hit_mcycle) begin
            w_mcycle_nxt = (XLEN == 64) ? 64'(w_wval) : {r_mcycle[63:32], w_wval[31:0]};
        end else if (w_wr_en && w_hit_mcycleh) begin
            w_mcycle_nxt = {w_wval[31:0], r_mcycle[31:0]};
        end
        if (w_wr_en && w_hit_minstret) begin
            w_minstret_nxt = (XLEN == 64) ? 64'(w_wval) : {r_minstret[63:32], w_wval[31:0]};
        end else if (w_wr_en && w_hit_minstreth) begin
            w_minstret_nxt = {w_wval[31:0], r_minstret[31:0]};
        end
    end

    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;
        end
    end

    // Trap/mret sequencer with registered redirect, plus the architectural CSRs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_ST_IDLE;
            r_mie            <= 1'b0;
            r_mpie           <= 1'b0;
            r_mtvec          <= '0;
            r_mepc           <= '0;
            r_mcause         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trap_take) begin
                        r_mepc           <= bus.trap_pc & c_ALIGN_MASK;
                        r_mcause         <= bus.trap_cause;
                        r_mpie           <= r_mie;
                        r_mie            <= 1'b0;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_mtvec;
                        r_state          <= c_ST_REDIRECT;
                    end else if (w_mret_take) begin
                        r_mie            <= r_mpie;
                        r_mpie           <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_mepc;
                        r_state          <= c_ST_REDIRECT;
                    end else if (w_wr_en) begin
                        if (w_hit_mstatus) begin
                            r_mie  <= w_wval[c_MIE_BIT];
                            r_mpie <= w_wval[c_MPIE_BIT];
                        end
                        if (w_hit_mtvec) begin
                            r_mtvec <= w_wval & c_ALIGN_MASK;
                        end
                        if (w_hit_mepc) begin
                            r_mepc <= w_wval & c_ALIGN_MASK;
                        end
                        if (w_hit_mcause) begin
                            r_mcause <= w_wval;
                        end
                    end
                end
                c_ST_REDIRECT: begin
                    r_redirect_valid <= 1'b0;
                    r_redirect_pc    <= '0;
                    r_state          <= c_ST_IDLE;
                end
                default: begin
                    r_redirect_valid <= 1'b0;
                    r_redirect_pc    <= '0;
                    r_state          <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.csr_rdata      = w_rdata;
    assign bus.csr_illegal    = w_illegal;
    assign bus.trap_ready     = w_trap_ready;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire
